// File: rtl/ssd_source_scheduler.sv
// rtl/ssd_source_scheduler.sv - round-robin stat source selector with iterative binary-to-BCD conversion
module ssd_source_scheduler #(
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] generation,
    input  logic [15:0] births,
    input  logic [15:0] deaths,
    input  logic [2:0]  src_enable,
    input  logic        hold,
    input  logic        next_req,
    output logic [15:0] bcd_digits,
    output logic [1:0]  src_sel,
    output logic        digits_valid,
    output logic        digits_stb,
    output logic        overflow
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL_CYCLES - 1);

    localparam logic [1:0] ST_LATCH   = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;
    localparam logic [1:0] ST_DECIDE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [15:0]   bcd_digits_q, bcd_digits_d;
    logic          overflow_q, overflow_d;
    logic          stb_q, stb_d;
    logic          valid_q, valid_d;
    logic [1:0]    src_sel_q, src_sel_d;
    logic          next_pend_q, next_pend_d;
    logic [CW-1:0] dwell_q, dwell_d;

    logic [15:0]   raw_val;
    logic [13:0]   clamped;
    logic [15:0]   bcd_adj;
    logic          en_cur;
    logic [1:0]    cand1, cand2, next_idx;
    logic          dwell_done;
    logic          adv;

    always_comb begin
        case (src_sel_q)
            2'd0:    raw_val = generation;
            2'd1:    raw_val = births;
            default: raw_val = deaths;
        endcase
        clamped = (raw_val > 16'd9999) ? 14'd9999 : raw_val[13:0];

        for (int i = 0; i < 4; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end

        case (src_sel_q)
            2'd0:    en_cur = src_enable[0];
            2'd1:    en_cur = src_enable[1];
            default: en_cur = src_enable[2];
        endcase

        // Search the two other positions in rotation order; fall back to staying put.
        cand1 = (src_sel_q == 2'd2) ? 2'd0 : src_sel_q + 2'd1;
        cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        if (src_enable[cand1])
            next_idx = cand1;
        else if (src_enable[cand2])
            next_idx = cand2;
        else
            next_idx = src_sel_q;

        dwell_done = (dwell_q == DWELL_MAX);
        adv = next_pend_q | (dwell_done & ~hold) | (~en_cur & (|src_enable));
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        ovf_pend_d   = ovf_pend_q;
        bcd_digits_d = bcd_digits_q;
        overflow_d   = overflow_q;
        stb_d        = 1'b0;
        valid_d      = valid_q;
        src_sel_d    = src_sel_q;
        next_pend_d  = next_pend_q | next_req;
        dwell_d      = dwell_done ? dwell_q : dwell_q + 1'b1;

        case (state_q)
            ST_LATCH: begin
                bin_d      = clamped;
                bcd_d      = 16'h0000;
                ovf_pend_d = (raw_val > 16'd9999);
                step_d     = 4'd0;
                state_d    = ST_CONVERT;
            end
            ST_CONVERT: begin
                bcd_d  = {bcd_adj[14:0], bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                step_d = step_q + 4'd1;
                if (step_q == 4'd13)
                    state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                bcd_digits_d = bcd_q;
                overflow_d   = ovf_pend_q;
                stb_d        = 1'b1;
                valid_d      = 1'b1;
                state_d      = ST_DECIDE;
            end
            default: begin
                // A request arriving in this very cycle survives into the next iteration.
                if (adv) begin
                    next_pend_d = next_req;
                    if (|src_enable) begin
                        src_sel_d = next_idx;
                        dwell_d   = '0;
                    end
                end
                state_d = ST_LATCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LATCH;
            step_q       <= 4'd0;
            bin_q        <= 14'd0;
            bcd_q        <= 16'h0000;
            ovf_pend_q   <= 1'b0;
            bcd_digits_q <= 16'h0000;
            overflow_q   <= 1'b0;
            stb_q        <= 1'b0;
            valid_q      <= 1'b0;
            src_sel_q    <= 2'd0;
            next_pend_q  <= 1'b0;
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            ovf_pend_q   <= ovf_pend_d;
            bcd_digits_q <= bcd_digits_d;
            overflow_q   <= overflow_d;
            stb_q        <= stb_d;
            valid_q      <= valid_d;
            src_sel_q    <= src_sel_d;
            next_pend_q  <= next_pend_d;
            dwell_q      <= dwell_d;
        end
    end

    assign bcd_digits   = bcd_digits_q;
    assign overflow     = overflow_q;
    assign digits_stb   = stb_q;
    assign digits_valid = valid_q;
    assign src_sel      = src_sel_q;

endmodule

// File: tb/tb_ssd_source_scheduler.sv
// tb/tb_ssd_source_scheduler.sv - directed vector bench for ssd_source_scheduler
module tb_ssd_source_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] generation, births, deaths;
    logic [2:0]  src_enable;
    logic        hold, next_req;
    logic [15:0] bcd_digits;
    logic [1:0]  src_sel;
    logic        digits_valid, digits_stb, overflow;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc_now = 0;

    ssd_source_scheduler #(.DWELL_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .generation(generation), .births(births), .deaths(deaths),
        .src_enable(src_enable), .hold(hold), .next_req(next_req),
        .bcd_digits(bcd_digits), .src_sel(src_sel),
        .digits_valid(digits_valid), .digits_stb(digits_stb), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    typedef struct {
        logic [15:0] gen;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vec_cnt++;
        if (act < lo || act > hi) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_stb(input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digits_stb === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check({name, "_stb_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_sel(input string name, input int bound, input logic [1:0] exp, output int t);
        logic [1:0] prev = src_sel;
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (src_sel !== prev) begin
                ok = 1;
                break;
            end
        end
        t = cyc_now;
        check({name, "_changed"}, 32'(ok), 32'd1);
        check({name, "_sel"}, 32'(src_sel), 32'(exp));
    endtask

    task automatic stay_sel(input string name, input int n, input logic [1:0] exp);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (src_sel !== exp) bad++;
        end
        check({name, "_bad_cycles"}, 32'(bad), 32'd0);
    endtask

    task automatic pulse_next();
        next_req = 1'b1;
        @(negedge clk);
        next_req = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int n, t0, t1, valid_early;

        vecs[0] = '{16'd0,     16'h0000, 1'b0};
        vecs[1] = '{16'd9,     16'h0009, 1'b0};
        vecs[2] = '{16'd10,    16'h0010, 1'b0};
        vecs[3] = '{16'd999,   16'h0999, 1'b0};
        vecs[4] = '{16'd9999,  16'h9999, 1'b0};
        vecs[5] = '{16'd10000, 16'h9999, 1'b1};
        vecs[6] = '{16'd65535, 16'h9999, 1'b1};

        rst_n = 1'b0; generation = 16'd1234; births = 16'd42; deaths = 16'd7;
        src_enable = 3'b111; hold = 1'b0; next_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bcd_digits), 32'h0);
        check("rst_sel", 32'(src_sel), 32'd0);
        check("rst_valid", 32'(digits_valid), 32'd0);
        check("rst_stb", 32'(digits_stb), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // First publish lands on the 16th edge after release.
        rst_n = 1'b1;
        n = 0; valid_early = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (digits_stb === 1'b1) begin n = i; break; end
            if (digits_valid !== 1'b0) valid_early++;
        end
        check("first_stb_latency", 32'(n), 32'd16);
        check("valid_before_stb", 32'(valid_early), 32'd0);
        check("first_bcd", 32'(bcd_digits), 32'h1234);
        check("first_ovf", 32'(overflow), 32'd0);
        check("first_sel", 32'(src_sel), 32'd0);
        check("first_valid", 32'(digits_valid), 32'd1);

        hold = 1'b1;
        foreach (vecs[k]) begin
            generation = vecs[k].gen;
            wait_stb($sformatf("vec%0d", k));
            check($sformatf("vec%0d_bcd", k), 32'(bcd_digits), 32'(vecs[k].exp_bcd));
            check($sformatf("vec%0d_ovf", k), 32'(overflow), 32'(vecs[k].exp_ovf));
            check($sformatf("vec%0d_sel", k), 32'(src_sel), 32'd0);
        end

        // Rotation, dwell already expired so the first advance is immediate.
        hold = 1'b0;
        wait_sel("rot01", 40, 2'd1, t0);
        wait_stb("rot_births");
        check("rot_births_bcd", 32'(bcd_digits), 32'h0042);
        wait_sel("rot12", 100, 2'd2, t1);
        check_range("rot12_interval", t1 - t0, 66, 82);
        wait_stb("rot_deaths");
        check("rot_deaths_bcd", 32'(bcd_digits), 32'h0007);
        wait_sel("rot20", 100, 2'd0, t0);
        check_range("rot20_interval", t0 - t1, 66, 82);

        hold = 1'b1;
        stay_sel("hold500", 500, 2'd0);

        wait_stb("midconv");
        repeat (6) @(negedge clk);
        pulse_next();
        wait_sel("next_mid", 20, 2'd1, t0);

        // Request and dwell expiry meet in the same DECIDE.
        hold = 1'b0;
        repeat (55) @(negedge clk);
        pulse_next();
        wait_sel("coincide", 40, 2'd2, t1);
        check_range("coincide_interval", t1 - t0, 66, 82);
        stay_sel("coincide_single", 40, 2'd2);

        src_enable = 3'b101;
        wait_sel("en101_a", 100, 2'd0, t0);
        wait_sel("en101_b", 100, 2'd2, t0);
        wait_sel("en101_c", 100, 2'd0, t0);
        src_enable = 3'b010;
        wait_sel("en010", 20, 2'd1, t0);
        stay_sel("en010_stay", 200, 2'd1);

        src_enable = 3'b000;
        pulse_next();
        stay_sel("en000_frozen", 200, 2'd1);
        src_enable = 3'b111; hold = 1'b1;
        stay_sel("pending_consumed", 40, 2'd1);

        pulse_next();
        wait_sel("to2", 20, 2'd2, t0);
        wait_stb("pre_rst");
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 32'(bcd_digits), 32'h0);
        check("midrst_sel", 32'(src_sel), 32'd0);
        check("midrst_valid", 32'(digits_valid), 32'd0);
        check("midrst_stb", 32'(digits_stb), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        generation = 16'd777;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_stb("post_rst");
        check("post_rst_bcd", 32'(bcd_digits), 32'h0777);
        check("post_rst_sel", 32'(src_sel), 32'd0);
        check("post_rst_valid", 32'(digits_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ssd_source_scheduler.md
# ssd_source_scheduler

Sequential controller that shares the 4-digit seven-segment display between three Game of Life statistics: generation, births and deaths. It rotates round-robin among the enabled sources and latches the selected 16-bit value. An iterative shift-add-3 (double-dabble) conversion then produces four BCD digits, so the digit-scan driver downstream needs no combinational division. The block sits between the simulation counters and the display driver.

## Interface
- DWELL_CYCLES, 100_000_000: clock cycles each source is shown before timer-driven advance (≥ 32).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- generation  in  16  source 0 value, binary.
- births  in  16  source 1 value, binary.
- deaths  in  16  source 2 value, binary.
- src_enable  in  3  bit i set means source i takes part in rotation.
- hold  in  1  level; suppresses timer-driven advance.
- next_req  in  1  single-cycle pulse; requests an immediate advance.
- bcd_digits  out  16  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- src_sel  out  2  source currently displayed (0/1/2); never 3.
- digits_valid  out  1  0 after reset; 1 from the first publish onward.
- digits_stb  out  1  one-cycle pulse on the cycle bcd_digits/overflow change.
- overflow  out  1  the published value was clamped.

## Operation
- FSM states are LATCH, CONVERT, PUBLISH and DECIDE. Reset enters LATCH.
- LATCH samples the value of src_sel.
  - A value > 9999 is clamped to 9999 with ovf_pending=1; otherwise ovf_pending=0.
  - The shift register is loaded with the 14-bit value, and the BCD accumulator is cleared.
- CONVERT runs for exactly 14 cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
- PUBLISH (1 cycle) registers the outputs:
  - bcd_digits ← accumulator.
  - overflow ← ovf_pending.
  - digits_stb=1 and digits_valid=1.
- DECIDE (1 cycle) sets adv = next_pending OR (dwell_done AND NOT hold) OR (src_enable[src_sel]==0 AND src_enable≠0).
  - If adv, src_sel moves to the next enabled index in order 0→1→2→0, skipping disabled ones.
  - If adv, next_pending and the dwell counter clear.
  - The FSM then returns to LATCH. The same source is re-converted continuously, so the display tracks live counts.
- next_pending is sticky: it is set in any cycle next_req=1 and cleared only in DECIDE when consumed.
- Dwell counter:
  - It increments every cycle and saturates at DWELL_CYCLES-1, at which point dwell_done=1.
  - It clears only on advance.
  - hold does not stop it, so releasing hold after expiry advances at the next DECIDE.
- If src_enable==0, src_sel is held at its current value and no advance occurs; next_pending is still consumed. If exactly one source is enabled, src_sel goes to and stays on it.
- Timer expiry and next_pending in the same DECIDE advance exactly one position.
- A change in src_enable takes effect at the next DECIDE. An in-flight conversion always completes and publishes.

## Timing
- A loop iteration is 17 cycles: LATCH 1, CONVERT 14, PUBLISH 1, DECIDE 1.
- Latency:
  - Inputs sampled at the edge ending LATCH (edge E0).
  - bcd_digits, overflow and digits_stb update at edge E15.
  - src_sel updates at edge E16.
- After an advance, the first value of the new source is published 16 edges after src_sel changes.
- digits_stb is high for exactly one cycle per iteration and low otherwise.
- Reset values (asynchronous, immediate):
  - bcd_digits=16'h0000, src_sel=0, digits_valid=0, digits_stb=0, overflow=0.
  - Dwell counter 0, next_pending 0, state LATCH.
- Reset asserted mid-CONVERT discards the conversion. Outputs read reset values until the first publish after release.
- Source inputs change asynchronously to this block's schedule. Only the LATCH-cycle sample matters, and no stability is required elsewhere.
- Worst-case outputs are registered. Combinational logic per CONVERT cycle is four nibble compare/add-3 units.

## Test plan
- Reset, DWELL_CYCLES=64, src_enable=3'b111, generation=1234 → digits_valid 0 until the first digits_stb 16 cycles after reset release; then bcd_digits=16'h1234, overflow=0, src_sel=0.
- Boundary values generation=0, 9, 10, 999, 9999, 10000, 65535 → 16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h9999, 16'h9999 (overflow=1), 16'h9999 (overflow=1).
- Rotation with births=42, deaths=7, hold=0 → src_sel 0→1→2→0. Each change occurs at the first DECIDE with counter expired (66–82 cycles apart). Published digits are 16'h0042, then 16'h0007.
- Control inputs:
  - hold=1 → src_sel stays 0 over 500 cycles.
  - A next_req pulse mid-CONVERT → advance at that iteration's DECIDE.
  - next_req coinciding with dwell expiry → advance by one only.
- src_enable=3'b101 → sequence 0→2→0. With src_enable=3'b010 while src_sel=0 → src_sel=1 at the next DECIDE, then stays there. With src_enable=3'b000 → src_sel frozen.
- Assert rst_n low on CONVERT cycle 7 after src_sel=2 → all outputs zero immediately. After release, src_sel=0, and the first publish shows the generation value.
